// File: rtl/imm_ext_pipe_if.sv
// ============================================================================
// imm_ext_pipe_if : valid/ready bus bundle for the immediate-extension stage
// Rev 1.0
// ============================================================================
`default_nettype none

interface imm_ext_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_imm, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_imm, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

`default_nettype wire

// File: rtl/imm_ext_pipe.sv
// ============================================================================
// imm_ext_pipe : registered immediate extension with a 2-entry skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  wire                clk,
  input  wire                rst,
  input  wire                flush,
  imm_ext_pipe_if.slave      bus
);

  localparam int E = OUT_W - IN_W;

  if (OUT_W < IN_W + 2) begin : g_bad_width
    $error("imm_ext_pipe: OUT_W must be at least IN_W+2");
  end

  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    sext = {{E{imm[IN_W-1]}}, imm};
    zext = {{E{1'b0}}, imm};
    case (mode)
      2'b00:   extend = sext;
      2'b01:   extend = zext;
      2'b10:   extend = zext << E;
      default: extend = sext << 2;
    endcase
  endfunction

  logic             main_valid_q, main_valid_d;
  logic [OUT_W-1:0] main_data_q,  main_data_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [OUT_W-1:0] skid_data_q,  skid_data_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;
  logic             in_ready_q,   in_ready_d;

  logic             accept;
  logic             drain;
  logic [OUT_W-1:0] ext_data;

  assign accept   = bus.in_valid && in_ready_q;
  assign drain    = main_valid_q && bus.out_ready;
  assign ext_data = extend(bus.in_imm, bus.in_mode);

  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || drain) begin
      // in_ready is low whenever skid holds data, so skid and input never race
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = ext_data;
        main_tag_d   = bus.in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_data;
      skid_tag_d   = bus.in_tag;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_valid_q;
  assign bus.out_data  = main_data_q;
  assign bus.out_tag   = main_tag_q;

endmodule

`default_nettype wire

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, registered immediate-extension stage for the decode (ID) path of the pipelined MIPS core.
- Supports four extension modes: sign, zero, upper (LUI) and branch-offset.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream stalls never combinationally depend on out_ready.
- Flush input lets hazard/branch logic squash in-flight immediates.

Parameters:
IN_W, 16, immediate input width.
OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W+2, otherwise elaboration fails.
TAG_W, 5, sideband tag carried with each immediate (e.g. destination register); passed through unchanged.

Ports:
clk  input  1  clock, all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
flush  input  1  synchronous squash of all buffered entries.
in_valid  input  1  upstream has an immediate.
in_ready  output  1  stage can accept; driven directly from a register.
in_imm  input  IN_W  raw immediate field.
in_mode  input  2  00 sign, 01 zero, 10 upper, 11 branch.
in_tag  input  TAG_W  sideband tag.
out_valid  output  1  out_data/out_tag valid.
out_ready  input  1  downstream accepts.
out_data  output  OUT_W  extended immediate.
out_tag  output  TAG_W  tag of out_data.

Behaviour:
- Extension, computed before capture; E = OUT_W-IN_W:
  - mode 00: {E{imm[IN_W-1]}, imm}.
  - mode 01: {E{0}, imm}.
  - mode 10: imm placed in the top IN_W bits, low E bits 0; requires E >= IN_W, else the result is imm shifted left by E and truncated to OUT_W.
  - mode 11: sign-extend to OUT_W, then shift left 2, dropping the top 2 bits.
- Accept: in_valid && in_ready at a rising edge.
- Drain: out_valid && out_ready at a rising edge.
- Storage: main register (drives outputs) plus skid register; each has a valid bit. Extended value and tag are stored, never the raw immediate.
- Latency: an item accepted at edge N is presented on out_* during the cycle after edge N, i.e. 1 cycle.
- Throughput: 1 item/cycle while out_ready=1.
- Next-state rules, evaluated in priority order:
  1. rst: both valid bits 0, out_data 0, out_tag 0, skid contents 0, in_ready 1. Any handshake in a rst cycle is ignored.
  2. flush: both valid bits 0 and in_ready 1. An input offered in the flush cycle is discarded even if in_ready was 1. A drain in the flush cycle still counts downstream; data/tag registers may keep stale values.
  3. Main empty, or main draining: main loads skid if skid valid; else loads the accepted input if any; else main valid goes 0.
  4. Main full and not draining, with an accept: the input goes to skid; skid valid 1.
  5. in_ready next = NOT(skid valid next).
- Accept cannot occur while skid is valid, because in_ready=0; skid and input never compete.
- Ordering: strict FIFO; the skid entry is always older than any later accept.
- out_data/out_tag hold stable while out_valid=1 and out_ready=0.
- No combinational path from out_ready or in_valid to in_ready.
- Reset values: out_valid 0, out_data 0, out_tag 0, in_ready 1.
- Reset mid-operation: buffered items are lost; the next cycle behaves as post-reset.

Test Plan:
- Modes (IN_W=16, OUT_W=32), out_ready=1:
  - 0x8001 mode 00 -> 0xFFFF8001; 0x8001 mode 01 -> 0x00008001.
  - 0x1234 mode 10 -> 0x12340000.
  - 0xFFFF mode 11 -> 0xFFFFFFFC; 0x0004 mode 11 -> 0x00000010.
  - Each appears one cycle after accept, with tag echoed.
- Streaming: 8 back-to-back items with out_ready=1 -> in_ready stays 1, 8 outputs on consecutive cycles, in order, no bubbles.
- Backpressure: out_ready=0, offer tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 the cycle after tag 2 is accepted, tag 3 held upstream. Raise out_ready -> outputs 1,2,3 in order, in_ready back to 1 after skid empties.
- Flush: with main and skid full, assert flush while in_valid=1 (tag 7) -> next cycle out_valid=0, in_ready=1, tag 7 never emitted.
- Reset mid-stream: rst pulse with both entries full and in_valid=1 -> next cycle out_valid=0, out_data=0, out_tag=0, in_ready=1; a following item emerges with 1-cycle latency.
- Stability: out_ready held 0 for 5 cycles -> out_data/out_tag/out_valid unchanged every cycle.
